// File: rtl/bch_chien_serial.sv
// Serial Chien search: evaluates the BMA error-locator polynomial at one codeword
// position per clock, streams data-bit error flags and reports a correctability verdict.
module bch_chien_serial #(
    parameter int M         = 4,
    parameter int POLY      = 19,
    parameter int T         = 3,
    parameter int DATA_BITS = 5,
    parameter int ECC_BITS  = 10
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic [(T+1)*M-1:0]                          sigma,
    input  logic [$clog2(T+1)-1:0]                      err_count,
    output logic                                        ready,
    output logic                                        err_valid,
    output logic                                        err,
    output logic                                        err_first,
    output logic                                        err_last,
    output logic                                        done,
    input  logic                                        ack_done,
    output logic                                        fail,
    output logic [$clog2(DATA_BITS+ECC_BITS+1)-1:0]     found
);

    localparam int N         = (1 << M) - 1;
    localparam int CODE_BITS = DATA_BITS + ECC_BITS;
    localparam int CW        = $clog2(CODE_BITS + 1);
    localparam int FW        = $clog2(CODE_BITS + 1);
    localparam int EW        = $clog2(T + 1);
    localparam int LOAD_EXP  = N - CODE_BITS + 1;

    localparam logic [M-1:0]  POLY_LOW  = M'(POLY);
    localparam logic [M-1:0]  GF_ONE    = M'(1);
    localparam logic [CW-1:0] LAST_POS  = CW'(CODE_BITS - 1);
    localparam logic [CW-1:0] DATA_CNT  = CW'(DATA_BITS);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
    localparam logic [FW-1:0] FOUND_MAX = {FW{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Multiply by alpha: shift left and reduce by the primitive polynomial.
    function automatic logic [M-1:0] mul_alpha(input logic [M-1:0] a);
        if (a[M-1]) begin
            return {a[M-2:0], 1'b0} ^ POLY_LOW;
        end else begin
            return {a[M-2:0], 1'b0};
        end
    endfunction

    function automatic logic [M-1:0] gf_pow(input int e);
        logic [M-1:0] p;
        p = GF_ONE;
        for (int k = 0; k < N; k++) begin
            if (k < e) begin
                p = mul_alpha(p);
            end else begin
                p = p;
            end
        end
        return p;
    endfunction

    // Shift-and-add multiply; with a constant operand this collapses to an XOR network.
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] acc;
        logic [M-1:0] x;
        acc = {M{1'b0}};
        x   = a;
        for (int k = 0; k < M; k++) begin
            if (b[k]) begin
                acc = acc ^ x;
            end else begin
                acc = acc;
            end
            x = mul_alpha(x);
        end
        return acc;
    endfunction

    state_t          state_r;
    state_t          state_nx_s;
    logic [M-1:0]    r_r    [0:T];
    logic [M-1:0]    load_s [0:T];
    logic [M-1:0]    step_s [0:T];
    logic [CW-1:0]   cnt_r;
    logic [FW-1:0]   found_r;
    logic [EW-1:0]   ec_r;
    logic [M-1:0]    sum_s;
    logic            hit_s;

    for (genvar j = 0; j <= T; j++) begin : g_coef
        localparam logic [M-1:0] LOAD_K = gf_pow((j * LOAD_EXP) % N);
        localparam logic [M-1:0] STEP_K = gf_pow(j % N);
        assign load_s[j] = gf_mul(sigma[j*M +: M], LOAD_K);
        assign step_s[j] = gf_mul(r_r[j], STEP_K);
    end

    // Locator value at the current position and its zero test.
    always_comb begin
        sum_s = {M{1'b0}};
        for (int j = 0; j <= T; j++) begin
            sum_s = sum_s ^ r_r[j];
        end
        hit_s = (sum_s == {M{1'b0}});
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nx_s = S_SCAN;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_SCAN: begin
                if (cnt_r == LAST_POS) begin
                    state_nx_s = S_DONE;
                end else begin
                    state_nx_s = S_SCAN;
                end
            end
            S_DONE: begin
                if (ack_done) begin
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_DONE;
                end
            end
            default: state_nx_s = S_IDLE;
        endcase
    end

    // Evaluation registers, position counter, root counter and latched error count.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j <= T; j++) begin
                r_r[j] <= {M{1'b0}};
            end
            cnt_r   <= {CW{1'b0}};
            found_r <= {FW{1'b0}};
            ec_r    <= {EW{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        r_r     <= load_s;
                        cnt_r   <= {CW{1'b0}};
                        found_r <= {FW{1'b0}};
                        ec_r    <= err_count;
                    end
                end
                S_SCAN: begin
                    r_r   <= step_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (hit_s && (found_r != FOUND_MAX)) begin
                        found_r <= found_r + FW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode from the registered state.
    always_comb begin
        ready     = 1'b0;
        err_valid = 1'b0;
        err       = 1'b0;
        err_first = 1'b0;
        err_last  = 1'b0;
        done      = 1'b0;
        fail      = 1'b0;
        case (state_r)
            S_IDLE: ready = 1'b1;
            S_SCAN: begin
                if (cnt_r < DATA_CNT) begin
                    err_valid = 1'b1;
                    err       = hit_s;
                    err_first = (cnt_r == {CW{1'b0}});
                    err_last  = (cnt_r == DATA_LAST);
                end else begin
                    err_valid = 1'b0;
                end
            end
            S_DONE: begin
                done = 1'b1;
                fail = (found_r != FW'(ec_r));
            end
            default: ready = 1'b0;
        endcase
    end

    assign found = found_r;

endmodule

// File: doc/bch_chien_serial.md
Name: bch_chien_serial

Overview:
- Error-locator evaluator (Chien search) that consumes the sigma / err_count result of the serial BMA stage.
- Turns the result into a per-bit error flag stream for the data bits, plus a correctability verdict.
- Sits downstream of the sigma solver. Its input handshake mirrors the solver's start/ready and done/ack_done conventions, so the two chain directly.
- Evaluates one codeword position per clock, using T parallel GF(2^M) constant multipliers.

Parameters:
- M, 4, field width; GF(2^M), N = 2^M-1.
- POLY, 19, primitive polynomial including the x^M term (19 = x^4+x+1).
- T, 3, correctable errors; sigma has T+1 coefficients.
- DATA_BITS, 5, data bits in the codeword, transmitted first.
- ECC_BITS, 10, parity bits. CODE_BITS = DATA_BITS+ECC_BITS, and CODE_BITS must be ≤ N.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  request; accepted only when start && ready.
- sigma  input  (T+1)*M  coefficient j at [j*M +: M]; coefficient 0 is nominally 1.
- err_count  input  $clog2(T+1)  error count from the BMA stage.
- ready  output  1  idle, able to accept start.
- err_valid  output  1  err carries a valid data-bit flag.
- err  output  1  1 means data bit err_index is in error.
- err_first  output  1  qualifies data bit 0.
- err_last  output  1  qualifies data bit DATA_BITS-1.
- done  output  1  result available; held until ack_done.
- ack_done  input  1  consumer acknowledge of done.
- fail  output  1  uncorrectable; valid while done.
- found  output  $clog2(CODE_BITS+1)  roots found; valid while done.

Behaviour:
- Bit mapping:
  - Stream index i = 0..CODE_BITS-1; i = 0 is the first transmitted bit.
  - Polynomial degree d = CODE_BITS-1-i.
  - Position i is in error iff sigma(alpha^(N-d)) == 0.
- Datapath:
  - T+1 M-bit registers r_j, for j = 0..T.
  - On accept, r_j <= sigma_j * alpha^(j*(N-CODE_BITS+1) mod N). These constants are computed by elaboration-time functions from M and POLY; no runtime tables.
  - Each SCAN cycle, r_j <= r_j * alpha^j (constant XOR network).
  - sum = XOR of all r_j. hit = (sum == 0).
- FSM:
  - IDLE: ready = 1. On start, latch sigma and err_count, load r_j, clear found and the position counter, go to SCAN. Start without ready is ignored.
  - SCAN: exactly CODE_BITS cycles. The cycle after the accepting edge is position 0. Each cycle: found += hit, counter += 1. After position CODE_BITS-1, go to DONE.
  - DONE: done = 1. fail = (found != latched err_count). On ack_done, go to IDLE; ready rises in the next cycle. ack_done outside DONE is ignored.
- Output stream:
  - err_valid = 1 only in SCAN cycles with counter < DATA_BITS.
  - err = hit in those cycles, else 0.
  - err_first = 1 when counter == 0; err_last = 1 when counter == DATA_BITS-1; both only while err_valid.
  - No backpressure; the consumer must sample every cycle.
- Parity-region roots (counter ≥ DATA_BITS) are counted in found but not streamed.
- Latency: first err_valid is 1 cycle after accept. done rises CODE_BITS+1 cycles after the accepting edge. Minimum start-to-start is CODE_BITS+2 cycles (done/ack_done same cycle).
- ready = 0 in SCAN and DONE. A start coinciding with ack_done in DONE is ignored.
- Reset values: state IDLE, ready = 1, and all of err_valid, err, err_first, err_last, done, fail, found, r_j = 0.
- Reset mid-SCAN or mid-DONE aborts immediately, with no done pulse.
- found saturates at its width maximum. It cannot overflow when CODE_BITS ≤ N.

Test Plan (M=4, POLY=19, T=3, DATA_BITS=5, ECC_BITS=10; evaluation point of position i is alpha^(1+i)):
- No errors: sigma=16'h0001, err_count=0 -> 5 err_valid cycles, all err=0, err_first on cycle 1, err_last on cycle 5. done at cycle 16 after accept, found=0, fail=0.
- Single data error: sigma=16'h00F1 (1+alpha^12·x), err_count=1 -> err=1 only at data bit 2 (3rd err_valid cycle); found=1, fail=0.
- Parity-only error: sigma=16'h0011 (1+x, position 14), err_count=1 -> no err=1 on the stream; found=1, fail=0.
- Mismatch: sigma=16'h00F1, err_count=2 -> err at bit 2, found=1, fail=1.
- Handshake:
  - start pulsed during SCAN and DONE -> ignored; ready stays 0.
  - done held ≥10 cycles without ack_done -> done/fail/found stable.
  - ack_done then start -> second job result correct.
- Reset at position 3 of SCAN -> next cycle: IDLE, ready=1, err_valid=0, done never asserts. A subsequent job runs normally.
